// File: rtl/cpri_pkg_arbiter.sv
// Round-robin whole-packet arbiter sharing one CPRI TX buffer write port; grant 1 cycle after request, write forwarded 1 cycle after i_wen.
// Losers hold i_req until granted; writes from non-granted requesters are dropped and flagged; stalled packets abort after TIMEOUT idle cycles.
module cpri_pkg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 64,
    parameter int AW      = 7,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [NUM_REQ-1:0]    i_req,
    output logic [NUM_REQ-1:0]    o_gnt,
    input  logic [NUM_REQ-1:0]    i_wen,
    input  logic [NUM_REQ*AW-1:0] i_waddr,
    input  logic [NUM_REQ*DW-1:0] i_wdata,
    input  logic [NUM_REQ-1:0]    i_wlast,
    output logic                  o_cpri_wen,
    output logic [AW-1:0]         o_cpri_waddr,
    output logic [DW-1:0]         o_cpri_wdata,
    output logic                  o_cpri_wlast,
    output logic                  o_abort,
    output logic                  o_err_unsol,
    output logic [15:0]           o_pkt_cnt,
    output logic                  o_busy
);

    localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          hi_vld;
    logic          lo_vld;
    logic          win_vld;
    logic [CW-1:0] idle_cnt;

    logic          sel_wen;
    logic          sel_wlast;
    logic [AW-1:0] sel_waddr;
    logic [DW-1:0] sel_wdata;
    logic          timeout_hit;
    logic          fwd;
    logic          pkt_done;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int r = NUM_REQ - 1; r >= 0; r--) begin
            if (i_req[r]) begin
                lo_vld = 1'b1;
                lo_idx = IW'(r);
                if (IW'(r) >= ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = IW'(r);
                end
            end
        end
        win_vld = lo_vld;
        win_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_wen   = 1'b0;
        sel_wlast = 1'b0;
        sel_waddr = '0;
        sel_wdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_idx == IW'(r)) begin
                sel_wen   = i_wen[r];
                sel_wlast = i_wlast[r];
                sel_waddr = i_waddr[r*AW +: AW];
                sel_wdata = i_wdata[r*DW +: DW];
            end
        end
    end

    assign next_ptr = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // An abort suppresses any beat that happens to arrive in the same cycle.
    assign timeout_hit = (state == GRANT) && (idle_cnt == CW'(TIMEOUT));
    assign fwd         = (state == GRANT) && !timeout_hit && sel_wen;
    assign pkt_done    = fwd && sel_wlast;
    assign o_busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_enable && win_vld) state_nxt = GRANT;
            GRANT:   if (timeout_hit || pkt_done) state_nxt = REL;
            REL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt_idx      <= '0;
            o_gnt        <= '0;
            idle_cnt     <= '0;
            o_cpri_wen   <= 1'b0;
            o_cpri_waddr <= '0;
            o_cpri_wdata <= '0;
            o_cpri_wlast <= 1'b0;
            o_abort      <= 1'b0;
            o_err_unsol  <= 1'b0;
            o_pkt_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            o_abort      <= timeout_hit;
            o_cpri_wen   <= fwd;
            o_cpri_wlast <= pkt_done;
            if (fwd) begin
                o_cpri_waddr <= sel_waddr;
                o_cpri_wdata <= sel_wdata;
            end
            // o_gnt is zero outside GRANT, so any strobe it does not cover is stray.
            if (|(i_wen & ~o_gnt)) begin
                o_err_unsol <= 1'b1;
            end
            if (pkt_done) begin
                o_pkt_cnt <= o_pkt_cnt + 16'd1;
            end
            if (state == IDLE && state_nxt == GRANT) begin
                gnt_idx  <= win_idx;
                o_gnt    <= NUM_REQ'(1) << win_idx;
                idle_cnt <= '0;
            end else if (state == GRANT) begin
                if (state_nxt == REL) begin
                    o_gnt <= '0;
                    ptr   <= next_ptr;
                end
                idle_cnt <= sel_wen ? '0 : idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpri_pkg_arbiter.sv
// Bench for cpri_pkg_arbiter: directed scenarios plus a randomized run against a packet-level round-robin model.
module tb_cpri_pkg_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 7;
    localparam int TO = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_enable;
    logic [N-1:0]    i_req;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    i_wen;
    logic [N*AW-1:0] i_waddr;
    logic [N*DW-1:0] i_wdata;
    logic [N-1:0]    i_wlast;
    logic            o_cpri_wen;
    logic [AW-1:0]   o_cpri_waddr;
    logic [DW-1:0]   o_cpri_wdata;
    logic            o_cpri_wlast;
    logic            o_abort;
    logic            o_err_unsol;
    logic [15:0]     o_pkt_cnt;
    logic            o_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpri_pkg_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_req(i_req), .o_gnt(o_gnt),
        .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wlast(i_wlast),
        .o_cpri_wen(o_cpri_wen), .o_cpri_waddr(o_cpri_waddr), .o_cpri_wdata(o_cpri_wdata),
        .o_cpri_wlast(o_cpri_wlast), .o_abort(o_abort), .o_err_unsol(o_err_unsol),
        .o_pkt_cnt(o_pkt_cnt), .o_busy(o_busy)
    );

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int r = 0; r < N; r++) if (v[r]) return r;
        return -1;
    endfunction

    task automatic clear_wr();
        i_wen   = '0;
        i_wlast = '0;
        i_waddr = '0;
        i_wdata = '0;
    endtask

    task automatic drive_beat(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
        i_wen[r]             = 1'b1;
        i_wlast[r]           = last;
        i_waddr[r*AW +: AW]  = a;
        i_wdata[r*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        i_req    = '0;
        i_enable = 1'b1;
        clear_wr();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for any grant; cyc = negedges waited, or -1 if the bound expired.
    task automatic wait_gnt(input int bound, output int cyc);
        cyc = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (o_gnt != '0) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        i_enable = 1'b1;
        i_req    = N'($urandom);
        i_wen    = N'($urandom);
        i_wlast  = N'($urandom);
        i_waddr  = (N*AW)'($urandom);
        i_wdata  = {N*2{$urandom}};
        @(negedge clk);
        n_vec++;
        if (o_gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", o_gnt); end
        n_vec++;
        if ({o_cpri_wen, o_cpri_wlast, o_abort, o_err_unsol, o_busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: wen/wlast/abort/err/busy got %b want 00000",
                     {o_cpri_wen, o_cpri_wlast, o_abort, o_err_unsol, o_busy});
        end
        n_vec++;
        if (o_cpri_waddr !== '0 || o_cpri_wdata !== '0) begin
            n_err++; $display("FAIL reset_bus: addr %h data %h want 0 0", o_cpri_waddr, o_cpri_wdata);
        end
        n_vec++;
        if (o_pkt_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", o_pkt_cnt); end
        i_req = '0;
        clear_wr();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        i_req = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (o_gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b want 0001", o_gnt); end
        i_req = '0;
        for (int b = 0; b < 4; b++) begin
            drive_beat(0, AW'(b), DW'('hA0 + b), b == 3);
            @(negedge clk);
            clear_wr();
            n_vec++;
            if (o_cpri_wen !== 1'b1 || o_cpri_waddr !== AW'(b) || o_cpri_wdata !== DW'('hA0 + b)
                || o_cpri_wlast !== (b == 3) || o_gnt !== ((b == 3) ? 4'b0000 : 4'b0001)) begin
                n_err++;
                $display("FAIL single_beat%0d: wen %b addr %0d data %h wlast %b gnt %b", b,
                         o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast, o_gnt);
            end
        end
        n_vec++;
        if (o_pkt_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", o_pkt_cnt); end
        @(negedge clk);
        n_vec++;
        if (o_cpri_wen !== 1'b0 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL single_tail: wen %b busy %b want 0 0", o_cpri_wen, o_busy);
        end
    endtask

    task automatic test_round_robin();
        int active, beat, ngr, last_end, g;
        logic exp_wen;
        logic [DW-1:0] exp_dat;
        do_reset();
        i_req = '1;
        active = -1; beat = 0; ngr = 0; last_end = -100; exp_wen = 1'b0; exp_dat = '0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (exp_wen) begin
                n_vec++;
                if (o_cpri_wen !== 1'b1 || o_cpri_wdata !== exp_dat) begin
                    n_err++; $display("FAIL rr_data: wen %b data %h want 1 %h", o_cpri_wen, o_cpri_wdata, exp_dat);
                end
            end
            clear_wr();
            exp_wen = 1'b0;
            if (active < 0 && o_gnt != '0) begin
                g = oh_idx(o_gnt);
                n_vec++;
                if (g != ngr % N || !$onehot(o_gnt)) begin
                    n_err++; $display("FAIL rr_order: grant %0d got %b want requester %0d", ngr, o_gnt, ngr % N);
                end
                if (ngr > 0) begin
                    n_vec++;
                    if (cyc - last_end != 3) begin
                        n_err++; $display("FAIL rr_gap: got %0d cycles want 3", cyc - last_end);
                    end
                end
                active = g; beat = 0; ngr++;
                if (ngr == 8) i_req = '0;
            end else if (active >= 0) begin
                n_vec++;
                if (o_gnt !== (N'(1) << active)) begin
                    n_err++; $display("FAIL rr_interleave: gnt %b want %b", o_gnt, N'(1) << active);
                end
            end
            if (active >= 0) begin
                exp_dat = DW'(active * 16 + beat);
                drive_beat(active, AW'(beat), exp_dat, beat == 1);
                exp_wen = 1'b1;
                if (beat == 1) begin
                    active = -1;
                    last_end = cyc;
                end
                beat++;
            end
        end
        n_vec++;
        if (ngr != 8) begin n_err++; $display("FAIL rr_grants: got %0d want 8", ngr); end
        n_vec++;
        if (o_pkt_cnt !== 16'd8) begin n_err++; $display("FAIL rr_cnt: got %0d want 8", o_pkt_cnt); end
    endtask

    task automatic test_timeout();
        int c, n;
        logic seen_wr;
        do_reset();
        i_req = 4'b1100;
        wait_gnt(4, c);
        n_vec++;
        if (c < 0 || o_gnt !== 4'b0100) begin n_err++; $display("FAIL to_gnt: got %b want 0100", o_gnt); end
        i_req = 4'b1000;
        n = 0;
        seen_wr = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (o_cpri_wen) seen_wr = 1'b1;
            if (o_abort) break;
        end
        n_vec++;
        if (n != TO + 1) begin n_err++; $display("FAIL to_latency: got %0d cycles want %0d", n, TO + 1); end
        n_vec++;
        if (o_gnt !== '0 || o_pkt_cnt !== 16'd0 || seen_wr) begin
            n_err++; $display("FAIL to_state: gnt %b cnt %0d wr %b want 0 0 0", o_gnt, o_pkt_cnt, seen_wr);
        end
        @(negedge clk);
        n_vec++;
        if (o_abort !== 1'b0) begin n_err++; $display("FAIL to_pulse: abort %b want 0", o_abort); end
        wait_gnt(4, c);
        n_vec++;
        if (o_gnt !== 4'b1000) begin n_err++; $display("FAIL to_next: got %b want 1000", o_gnt); end
    endtask

    task automatic test_unsol();
        int c;
        do_reset();
        i_req = 4'b0010;
        wait_gnt(4, c);
        n_vec++;
        if (o_gnt !== 4'b0010) begin n_err++; $display("FAIL us_gnt: got %b want 0010", o_gnt); end
        i_req = '0;
        drive_beat(3, 7'h55, 64'hDEAD, 1'b1);
        @(negedge clk);
        clear_wr();
        n_vec++;
        if (o_cpri_wen !== 1'b0 || o_err_unsol !== 1'b1) begin
            n_err++; $display("FAIL us_drop: wen %b err %b want 0 1", o_cpri_wen, o_err_unsol);
        end
        n_vec++;
        if (o_gnt !== 4'b0010 || o_pkt_cnt !== 16'd0) begin
            n_err++; $display("FAIL us_keep: gnt %b cnt %0d want 0010 0", o_gnt, o_pkt_cnt);
        end
        drive_beat(1, 7'h11, 64'h1111, 1'b1);
        @(negedge clk);
        clear_wr();
        n_vec++;
        if (o_cpri_wen !== 1'b1 || o_cpri_wdata !== 64'h1111 || o_cpri_wlast !== 1'b1) begin
            n_err++; $display("FAIL us_fwd: wen %b data %h wlast %b want 1 1111 1", o_cpri_wen, o_cpri_wdata, o_cpri_wlast);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (o_err_unsol !== 1'b1) begin n_err++; $display("FAIL us_sticky: got %b want 1", o_err_unsol); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (o_err_unsol !== 1'b0) begin n_err++; $display("FAIL us_rst: got %b want 0", o_err_unsol); end
    endtask

    task automatic test_enable();
        int c;
        logic bad;
        do_reset();
        i_req = 4'b0011;
        wait_gnt(4, c);
        n_vec++;
        if (o_gnt !== 4'b0001) begin n_err++; $display("FAIL en_gnt0: got %b want 0001", o_gnt); end
        i_req = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            drive_beat(0, AW'(b), DW'('hE0 + b), b == 2);
            if (b == 0) i_enable = 1'b0;
            @(negedge clk);
            clear_wr();
            n_vec++;
            if (o_cpri_wen !== 1'b1 || o_cpri_waddr !== AW'(b) || o_cpri_wdata !== DW'('hE0 + b)) begin
                n_err++; $display("FAIL en_beat%0d: wen %b addr %0d data %h", b, o_cpri_wen, o_cpri_waddr, o_cpri_wdata);
            end
        end
        n_vec++;
        if (o_pkt_cnt !== 16'd1) begin n_err++; $display("FAIL en_cnt: got %0d want 1", o_pkt_cnt); end
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_gnt != '0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin n_err++; $display("FAIL en_block: grant seen %b want none", bad); end
        i_enable = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_gnt !== 4'b0010) begin n_err++; $display("FAIL en_regrant: got %b want 0010", o_gnt); end
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        i_req = 4'b0001;
        wait_gnt(4, c);
        i_req = '0;
        drive_beat(0, 7'd0, 64'h1, 1'b1);
        @(negedge clk);
        clear_wr();
        i_req = 4'b0010;
        wait_gnt(6, c);
        n_vec++;
        if (o_gnt !== 4'b0010) begin n_err++; $display("FAIL rm_gnt1: got %b want 0010", o_gnt); end
        i_req = '0;
        for (int b = 0; b < 2; b++) begin
            drive_beat(1, AW'(b), DW'('hB0 + b), 1'b0);
            @(negedge clk);
            clear_wr();
        end
        drive_beat(1, 7'd2, 64'hB2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (o_gnt !== '0 || {o_cpri_wen, o_cpri_wlast, o_abort, o_err_unsol, o_busy} !== 5'b0
            || o_cpri_waddr !== '0 || o_cpri_wdata !== '0 || o_pkt_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rm_clear: gnt %b wen %b busy %b addr %h data %h cnt %0d", o_gnt, o_cpri_wen,
                     o_busy, o_cpri_waddr, o_cpri_wdata, o_pkt_cnt);
        end
        clear_wr();
        rst = 1'b0;
        i_req = 4'b0101;
        @(negedge clk);
        n_vec++;
        if (o_gnt !== 4'b0001) begin n_err++; $display("FAIL rm_first: got %b want 0001", o_gnt); end
    endtask

    task automatic test_random();
        logic [N-1:0]  pend;
        int            active, left, last_end, mptr, want_g;
        logic          exp_wen, exp_last;
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] exp_dat;
        logic [15:0]   exp_cnt;
        do_reset();
        pend = '0; active = -1; left = 0; last_end = -100; mptr = 0;
        exp_wen = 1'b0; exp_last = 1'b0; exp_adr = '0; exp_dat = '0; exp_cnt = '0;
        for (int cyc = 1; cyc <= 1500; cyc++) begin
            @(negedge clk);
            n_vec++;
            if (o_cpri_wen !== exp_wen || o_pkt_cnt !== exp_cnt || o_abort !== 1'b0 || o_err_unsol !== 1'b0
                || (exp_wen && (o_cpri_waddr !== exp_adr || o_cpri_wdata !== exp_dat || o_cpri_wlast !== exp_last))) begin
                n_err++;
                $display("FAIL rnd_write@%0d: wen %b addr %h data %h last %b cnt %0d want %b %h %h %b %0d", cyc,
                         o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast, o_pkt_cnt,
                         exp_wen, exp_adr, exp_dat, exp_last, exp_cnt);
            end
            clear_wr();
            exp_wen = 1'b0;
            if (active >= 0) begin
                n_vec++;
                if (o_gnt !== (N'(1) << active)) begin
                    n_err++; $display("FAIL rnd_hold@%0d: gnt %b want %b", cyc, o_gnt, N'(1) << active);
                end
            end else begin
                want_g = -1;
                if (pend != '0 && cyc - last_end >= 3) begin
                    for (int k = 0; k < N; k++) begin
                        if (want_g < 0 && pend[(mptr + k) % N]) want_g = (mptr + k) % N;
                    end
                end
                n_vec++;
                if ((want_g < 0) ? (o_gnt !== '0) : (o_gnt !== (N'(1) << want_g))) begin
                    n_err++; $display("FAIL rnd_grant@%0d: gnt %b want requester %0d", cyc, o_gnt, want_g);
                end
                if (want_g >= 0) begin
                    active = want_g;
                    pend[active] = 1'b0;
                    i_req[active] = 1'b0;
                    left = $urandom_range(1, 4);
                end
            end
            if (active >= 0 && $urandom_range(0, 3) != 0) begin
                exp_adr  = AW'($urandom);
                exp_dat  = {$urandom, $urandom};
                exp_last = (left == 1);
                drive_beat(active, exp_adr, exp_dat, exp_last);
                exp_wen = 1'b1;
                left--;
                if (left == 0) begin
                    exp_cnt++;
                    last_end = cyc;
                    mptr = (active + 1) % N;
                    active = -1;
                end
            end
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    i_req[r] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0;
        i_req = '0;
        clear_wr();
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_unsol();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
